// File: rtl/pc_redirect_unit_pkg.sv
// Shared pipeline definitions for the fetch-PC redirect logic.
// Holds the default reset PC and the fetch increment.
// Holds the RUN/PEND state encoding.
// Holds the target alignment helper used by every PC load path.
package pc_redirect_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // RUN: no redirect outstanding; PEND: a target is parked in pend_pc
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } redir_state_e;

    // Force a redirect target onto a word boundary
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_unit_redirect_buf.sv
// redirect_buf: parks a redirect target while instruction memory is busy.
// Ports:
//   clk, rst_n   - clock and async active-low reset
//   redirect     - taken branch/jump this cycle
//   imem_ready   - instruction memory accepts the current pc
//   target       - aligned redirect target
//   pend_pc      - parked target (valid while release_hit)
//   release_hit  - parked target is loaded into pc on this edge
module redirect_buf
    import pc_redirect_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic        imem_ready,
    input  logic [31:0] target,
    output logic [31:0] pend_pc,
    output logic        release_hit
);

    redir_state_e state_r;
    redir_state_e state_nxt_s;
    logic [31:0]  pend_pc_r;
    logic [31:0]  pend_nxt_s;

    // Next state and parked target; a new redirect always wins over a parked one
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_pc_r;
        if (redirect) begin
            if (imem_ready) begin
                state_nxt_s = RUN;
            end else begin
                state_nxt_s = PEND;
                pend_nxt_s  = target;
            end
        end else if ((state_r == PEND) && imem_ready) begin
            state_nxt_s = RUN;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and parked-target registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RUN;
            pend_pc_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            pend_pc_r <= pend_nxt_s;
        end
    end

    assign pend_pc     = pend_pc_r;
    assign release_hit = (state_r == PEND) && imem_ready && !redirect;

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch/jump redirect handling.
// Ports:
//   cpu_clk, cpu_rst_n - clock and async active-low reset
//   npc_op, npc_bj     - redirect request and its target
//   stall              - load-use hold
//   imem_ready         - instruction memory accepts pc this cycle
//   pc, pc4            - fetch address (registered) and pc+4 (combinational)
//   flush_ifid/idex    - pipeline kill, same cycle as npc_op
//   misalign_err       - sticky: some redirect target was not word aligned
//   redirect_cnt       - number of redirect cycles seen
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        npc_op,
    input  logic [31:0] npc_bj,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        misalign_err,
    output logic [31:0] redirect_cnt
);

    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] target_s;
    logic [31:0] pend_pc_s;
    logic        release_s;
    logic        misalign_r;
    logic [31:0] cnt_r;

    assign target_s = align_target(npc_bj);

    redirect_buf u_redirect_buf (
        .clk         (cpu_clk),
        .rst_n       (cpu_rst_n),
        .redirect    (npc_op),
        .imem_ready  (imem_ready),
        .target      (target_s),
        .pend_pc     (pend_pc_s),
        .release_hit (release_s)
    );

    // Next-pc priority: live redirect, parked redirect, hold, sequential
    always_comb begin
        pc_nxt_s = pc_r;
        if (npc_op && imem_ready) begin
            pc_nxt_s = target_s;
        end else if (npc_op) begin
            pc_nxt_s = pc_r;
        end else if (release_s) begin
            pc_nxt_s = pend_pc_s;
        end else if (stall || !imem_ready) begin
            pc_nxt_s = pc_r;
        end else begin
            pc_nxt_s = pc_r + PC_INC;
        end
    end

    // PC register
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    // Sticky misalignment flag and redirect counter (wraps naturally)
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            misalign_r <= 1'b0;
            cnt_r      <= 32'h0000_0000;
        end else begin
            if (npc_op && (npc_bj[1:0] != 2'b00)) begin
                misalign_r <= 1'b1;
            end
            if (npc_op) begin
                cnt_r <= cnt_r + 32'd1;
            end
        end
    end

    assign pc           = pc_r;
    assign pc4          = pc_r + PC_INC;
    assign flush_ifid   = npc_op;
    assign flush_idex   = npc_op;
    assign misalign_err = misalign_r;
    assign redirect_cnt = cnt_r;

endmodule
